bus_arbiter: RTL

- Shares the single system-bus slave port between two masters (m0, m1) using round-robin arbitration.
- Decodes the address to a one-hot slave select and issues a one-cycle valid strobe to the selected slave.
- Waits for the slave's response pulse, returns read data and a done/error pulse to the granted master.
- Sits between the master ports and the memory slaves (slave_1 and siblings); also guards against hung slaves with a timeout.

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_if.sv | 52 +++++
 rtl/bus_arbiter_rr_arb2.sv | 43 ++++
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master system-bus arbiter.
package bus_arb_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned SLV_IDX_MSB = 13;
    localparam int unsigned SLV_IDX_LSB = 12;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Slave index field of a byte address.
    function automatic logic [1:0] slave_idx(input logic [ADDR_W-1:0] addr);
        return addr[SLV_IDX_MSB:SLV_IDX_LSB];
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the master request/response ports and the shared slave bus.
// "master" is the arbiter's view (it masters the slave bus); "slave" is the
// view of the requesting masters plus the memory slaves.
interface bus_arbiter_if import bus_arb_pkg::*; #(
    parameter int unsigned NUM_SLAVES = 3
) ();

    logic                         m0_req;
    logic                         m0_mode;
    logic [ADDR_W-1:0]            m0_addr;
    logic [DATA_W-1:0]            m0_wdata;
    logic                         m0_grant;
    logic [DATA_W-1:0]            m0_rdata;
    logic                         m0_done;
    logic                         m0_err;

    logic                         m1_req;
    logic                         m1_mode;
    logic [ADDR_W-1:0]            m1_addr;
    logic [DATA_W-1:0]            m1_wdata;
    logic                         m1_grant;
    logic [DATA_W-1:0]            m1_rdata;
    logic                         m1_done;
    logic                         m1_err;

    logic                         s_mode;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic                         s_valid;
    logic [NUM_SLAVES-1:0]        s_select;
    logic [DATA_W*NUM_SLAVES-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_rvalid;

    modport master (
        input  m0_req, m0_mode, m0_addr, m0_wdata,
        output m0_grant, m0_rdata, m0_done, m0_err,
        input  m1_req, m1_mode, m1_addr, m1_wdata,
        output m1_grant, m1_rdata, m1_done, m1_err,
        output s_mode, s_addr, s_wdata, s_valid, s_select,
        input  s_rdata, s_rvalid
    );

    modport slave (
        output m0_req, m0_mode, m0_addr, m0_wdata,
        input  m0_grant, m0_rdata, m0_done, m0_err,
        output m1_req, m1_mode, m1_addr, m1_wdata,
        input  m1_grant, m1_rdata, m1_done, m1_err,
        input  s_mode, s_addr, s_wdata, s_valid, s_select,
        output s_rdata, s_rvalid
    );

endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-requester round-robin picker. On contention the requester that was not
// served last wins; after reset m0 is favoured.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    // Next pointer: the master just served, when the transaction completes.
    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = served_i;
        end
    end

    // Pointer register; reset value 1 makes m0 win the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // One-hot grant from the current requests and the pointer.
    always_comb begin
        grant_o = '0;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system-bus slave port between two masters,
// with address decode to a one-hot slave select and a hung-slave timeout.
module bus_arbiter import bus_arb_pkg::*; #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);

    state_t                       state_q;
    logic                         who_q;
    logic [1:0]                   gnt_q;
    logic [7:0]                   cnt_q;
    logic [NUM_SLAVES-1:0]        sel_q;
    logic                         valid_q;
    logic                         mode_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [DATA_W-1:0]            wdata_q;
    logic [1:0]                   done_q;
    logic [1:0]                   err_q;
    logic [1:0][DATA_W-1:0]       rdata_q;

    logic [1:0]                   pick;
    logic                         cand_mode;
    logic [ADDR_W-1:0]            cand_addr;
    logic [DATA_W-1:0]            cand_wdata;
    logic [1:0]                   cand_idx;
    logic                         cand_mapped;
    logic [NUM_SLAVES-1:0]        cand_sel;
    logic                         hit;
    logic [DATA_W-1:0]            hit_data;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({bus.m1_req, bus.m0_req}),
        .update_i (state_q == DONE),
        .served_i (who_q),
        .grant_o  (pick)
    );

    // Request fields of the arbitration winner and their address decode.
    always_comb begin
        cand_mode  = bus.m0_mode;
        cand_addr  = bus.m0_addr;
        cand_wdata = bus.m0_wdata;
        if (pick[1]) begin
            cand_mode  = bus.m1_mode;
            cand_addr  = bus.m1_addr;
            cand_wdata = bus.m1_wdata;
        end
    end

    assign cand_idx    = slave_idx(cand_addr);
    assign cand_mapped = 32'(cand_idx) < NUM_SLAVES;
    assign cand_sel    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << cand_idx;

    // Response from the selected slave only; others are masked off.
    always_comb begin
        hit      = |(bus.s_rvalid & sel_q);
        hit_data = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                hit_data = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM; every bus and master output comes straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            who_q   <= 1'b0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|pick) begin
                        who_q   <= pick[1];
                        gnt_q   <= pick;
                        mode_q  <= cand_mode;
                        addr_q  <= cand_addr;
                        wdata_q <= cand_wdata;
                        if (cand_mapped) begin
                            sel_q   <= cand_sel;
                            valid_q <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            done_q  <= pick;
                            err_q   <= pick;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (hit) begin
                        done_q[who_q]  <= 1'b1;
                        rdata_q[who_q] <= hit_data;
                        sel_q          <= '0;
                        state_q        <= DONE;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        done_q[who_q] <= 1'b1;
                        err_q[who_q]  <= 1'b1;
                        sel_q         <= '0;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m0_grant = gnt_q[0];
    assign bus.m0_done  = done_q[0];
    assign bus.m0_err   = err_q[0];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_grant = gnt_q[1];
    assign bus.m1_done  = done_q[1];
    assign bus.m1_err   = err_q[1];
    assign bus.m1_rdata = rdata_q[1];
    assign bus.s_mode   = mode_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.s_valid  = valid_q;
    assign bus.s_select = sel_q;

endmodule
